// File: rtl/issue_scoreboard.sv
// Decode-to-execute issue controller: one-entry instruction buffer, register
// scoreboard for RAW/WAW hazards, and the illegal-instruction drain/trap sequence.
module issue_scoreboard #(
  parameter int NB_REG  = 32,
  parameter int NB_UNIT = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_valid_i,
  output logic               dec_ready_o,
  input  logic               illegal_inst_i,
  input  logic               rd_v_i,
  input  logic [4:0]         rd_i,
  input  logic               rs1_v_i,
  input  logic [4:0]         rs1_adr_i,
  input  logic               rs2_v_i,
  input  logic [4:0]         rs2_adr_i,
  input  logic [NB_UNIT-1:0] unit_i,
  input  logic [NB_UNIT-1:0] unit_busy_i,
  output logic               issue_valid_o,
  input  logic               issue_ready_i,
  output logic               issue_rd_v_o,
  output logic [4:0]         issue_rd_o,
  output logic [NB_UNIT-1:0] issue_unit_o,
  input  logic               wb_valid_i,
  input  logic [4:0]         wb_rd_i,
  input  logic               flush_i,
  output logic               exception_o,
  output logic [NB_REG-1:0]  pending_o
);

  typedef enum logic [1:0] {RUN, DRAIN, EXC, HALT} state_t;

  state_t               state_q, state_d;
  logic                 buf_v_q, buf_v_d;
  logic                 buf_illegal_q, buf_illegal_d;
  logic                 buf_rd_v_q, buf_rd_v_d;
  logic [4:0]           buf_rd_q, buf_rd_d;
  logic                 buf_rs1_v_q, buf_rs1_v_d;
  logic [4:0]           buf_rs1_q, buf_rs1_d;
  logic                 buf_rs2_v_q, buf_rs2_v_d;
  logic [4:0]           buf_rs2_q, buf_rs2_d;
  logic [NB_UNIT-1:0]   buf_unit_q, buf_unit_d;
  logic [NB_REG-1:0]    pending_q, pending_d;
  logic                 exception_q, exception_d;

  logic [NB_REG-1:0]    wb_mask;
  logic [NB_REG-1:0]    eff_pending;
  logic                 hazard, unit_blk, issue_fire, dec_fire;

  // A writeback in the current cycle already frees its register for the check.
  always_comb begin
    wb_mask = '0;
    if (wb_valid_i) wb_mask[wb_rd_i] = 1'b1;
    eff_pending = pending_q & ~wb_mask;
  end

  assign hazard = (buf_rs1_v_q & eff_pending[buf_rs1_q])
                | (buf_rs2_v_q & eff_pending[buf_rs2_q])
                | (buf_rd_v_q & (buf_rd_q != 5'd0) & eff_pending[buf_rd_q]);
  assign unit_blk = |(buf_unit_q & unit_busy_i);

  assign issue_valid_o = buf_v_q & ~buf_illegal_q & ~hazard & ~unit_blk
                       & (state_q == RUN) & ~flush_i;
  assign issue_fire    = issue_valid_o & issue_ready_i;
  assign dec_ready_o   = ~rst & (state_q == RUN) & ~flush_i & (~buf_v_q | issue_fire);
  assign dec_fire      = dec_valid_i & dec_ready_o;

  assign issue_rd_v_o = buf_rd_v_q;
  assign issue_rd_o   = buf_rd_q;
  assign issue_unit_o = buf_unit_q;
  assign pending_o    = pending_q;
  assign exception_o  = exception_q & ~flush_i;

  always_comb begin
    state_d       = state_q;
    buf_v_d       = buf_v_q;
    buf_illegal_d = buf_illegal_q;
    buf_rd_v_d    = buf_rd_v_q;
    buf_rd_d      = buf_rd_q;
    buf_rs1_v_d   = buf_rs1_v_q;
    buf_rs1_d     = buf_rs1_q;
    buf_rs2_v_d   = buf_rs2_v_q;
    buf_rs2_d     = buf_rs2_q;
    buf_unit_d    = buf_unit_q;
    pending_d     = pending_q;
    exception_d   = 1'b0;

    // Clear before set so an issue and a writeback of the same register leave it pending.
    if (wb_valid_i) pending_d[wb_rd_i] = 1'b0;
    if (issue_fire && buf_rd_v_q && buf_rd_q != 5'd0) pending_d[buf_rd_q] = 1'b1;
    pending_d[0] = 1'b0;

    if (issue_fire) buf_v_d = 1'b0;
    if (dec_fire) begin
      buf_v_d       = 1'b1;
      buf_illegal_d = illegal_inst_i;
      buf_rd_v_d    = rd_v_i;
      buf_rd_d      = rd_i;
      buf_rs1_v_d   = rs1_v_i;
      buf_rs1_d     = rs1_adr_i;
      buf_rs2_v_d   = rs2_v_i;
      buf_rs2_d     = rs2_adr_i;
      buf_unit_d    = unit_i;
    end

    case (state_q)
      RUN:   if (buf_v_q && buf_illegal_q) state_d = DRAIN;
      DRAIN: if (eff_pending == '0) begin
               state_d     = EXC;
               exception_d = 1'b1;
             end
      EXC: begin
             buf_v_d = 1'b0;
             state_d = HALT;
           end
      default: state_d = HALT;
    endcase

    if (flush_i) begin
      state_d     = RUN;
      buf_v_d     = 1'b0;
      pending_d   = '0;
      exception_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      buf_v_q       <= 1'b0;
      buf_illegal_q <= 1'b0;
      buf_rd_v_q    <= 1'b0;
      buf_rd_q      <= '0;
      buf_rs1_v_q   <= 1'b0;
      buf_rs1_q     <= '0;
      buf_rs2_v_q   <= 1'b0;
      buf_rs2_q     <= '0;
      buf_unit_q    <= '0;
      pending_q     <= '0;
      exception_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_v_q       <= buf_v_d;
      buf_illegal_q <= buf_illegal_d;
      buf_rd_v_q    <= buf_rd_v_d;
      buf_rd_q      <= buf_rd_d;
      buf_rs1_v_q   <= buf_rs1_v_d;
      buf_rs1_q     <= buf_rs1_d;
      buf_rs2_v_q   <= buf_rs2_v_d;
      buf_rs2_q     <= buf_rs2_d;
      buf_unit_q    <= buf_unit_d;
      pending_q     <= pending_d;
      exception_q   <= exception_d;
    end
  end

endmodule
